// File: rtl/one_wire_rom_id_ctrl.sv
// one_wire_rom_id_ctrl: collects a 1-Wire ROM ID byte stream, replays it
// LSB-first into a bit-serial CRC-8 engine and judges the engine result.
// Optional build macro ONE_WIRE_FAMILY_CHECK_EN adds a family-code check
// and the family_err output.
module one_wire_rom_id_ctrl #(
   parameter int         NUM_BYTES      = 8,
   parameter int         TIMEOUT_CYCLES = 16,
   parameter logic [7:0] FAMILY_CODE    = 8'h28
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   byte_valid,
   input  logic [7:0]             byte_data,
   output logic                   byte_ready,
   output logic                   crc_start,
   output logic                   crc_bit,
   input  logic [7:0]             crc_data,
   input  logic                   crc_valid,
   output logic                   busy,
   output logic                   done,
   output logic                   id_ok,
   output logic                   err_crc,
   output logic                   err_timeout,
   output logic [NUM_BYTES*8-1:0] rom_id
`ifdef ONE_WIRE_FAMILY_CHECK_EN
   ,
   output logic                   family_err
`endif
);

   localparam int NBITS = NUM_BYTES * 8;
   localparam int BCW   = $clog2(NUM_BYTES);
   localparam int ICW   = $clog2(NBITS);
   localparam int TCW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [BCW-1:0] LAST_BYTE = BCW'(NUM_BYTES - 1);
   localparam logic [ICW-1:0] LAST_BIT  = ICW'(NBITS - 1);
   localparam logic [TCW-1:0] LAST_WAIT = TCW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_STREAM,
      S_WAIT,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [BCW-1:0]   byte_cnt_q, byte_cnt_d;
   logic [ICW-1:0]   bit_idx_q, bit_idx_d;
   logic [TCW-1:0]   tcnt_q, tcnt_d;
   logic [NBITS-1:0] rom_id_q, rom_id_d;
   logic             byte_ready_q, byte_ready_d;
   logic             crc_start_q, crc_start_d;
   logic             crc_bit_q, crc_bit_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             id_ok_q, id_ok_d;
   logic             err_crc_q, err_crc_d;
   logic             err_timeout_q, err_timeout_d;
   logic             fam_bad;
`ifdef ONE_WIRE_FAMILY_CHECK_EN
   logic             family_err_q, family_err_d;
`endif

   // Next-state and registered-output computation for the sequencer.
   always_comb begin
      state_d       = state_q;
      byte_cnt_d    = byte_cnt_q;
      bit_idx_d     = bit_idx_q;
      tcnt_d        = tcnt_q;
      rom_id_d      = rom_id_q;
      byte_ready_d  = byte_ready_q;
      crc_start_d   = 1'b0;
      crc_bit_d     = 1'b0;
      done_d        = 1'b0;
      id_ok_d       = id_ok_q;
      err_crc_d     = err_crc_q;
      err_timeout_d = err_timeout_q;
`ifdef ONE_WIRE_FAMILY_CHECK_EN
      fam_bad       = (rom_id_q[7:0] != FAMILY_CODE);
      family_err_d  = family_err_q;
`else
      fam_bad       = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d       = S_COLLECT;
               byte_cnt_d    = '0;
               byte_ready_d  = 1'b1;
               id_ok_d       = 1'b0;
               err_crc_d     = 1'b0;
               err_timeout_d = 1'b0;
`ifdef ONE_WIRE_FAMILY_CHECK_EN
               family_err_d  = 1'b0;
`endif
            end
         end
         S_COLLECT: begin
            if (byte_valid && byte_ready_q) begin
               for (int k = 0; k < NUM_BYTES; k++) begin
                  if (byte_cnt_q == BCW'(k)) rom_id_d[8*k +: 8] = byte_data;
               end
               if (byte_cnt_q == LAST_BYTE) begin
                  // Byte 0 is already stored, so bit 0 can launch right away.
                  state_d      = S_STREAM;
                  byte_ready_d = 1'b0;
                  bit_idx_d    = '0;
                  crc_start_d  = 1'b1;
                  crc_bit_d    = rom_id_q[0];
               end else begin
                  byte_cnt_d = byte_cnt_q + BCW'(1);
               end
            end
         end
         S_STREAM: begin
            if (bit_idx_q == LAST_BIT) begin
               state_d = S_WAIT;
               tcnt_d  = '0;
            end else begin
               bit_idx_d = bit_idx_q + ICW'(1);
               crc_bit_d = rom_id_q[bit_idx_q + ICW'(1)];
            end
         end
         S_WAIT: begin
            // A result on the final allowed cycle wins over the timeout.
            if (crc_valid) begin
               state_d       = S_DONE;
               done_d        = 1'b1;
               err_crc_d     = (crc_data != 8'h00);
               err_timeout_d = 1'b0;
               id_ok_d       = (crc_data == 8'h00) && !fam_bad;
`ifdef ONE_WIRE_FAMILY_CHECK_EN
               family_err_d  = fam_bad;
`endif
            end else if (tcnt_q == LAST_WAIT) begin
               state_d       = S_DONE;
               done_d        = 1'b1;
               err_crc_d     = 1'b0;
               err_timeout_d = 1'b1;
               id_ok_d       = 1'b0;
`ifdef ONE_WIRE_FAMILY_CHECK_EN
               family_err_d  = fam_bad;
`endif
            end else begin
               tcnt_d = tcnt_q + TCW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State, counters, captured ID and all outputs; reset aborts everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         byte_cnt_q    <= '0;
         bit_idx_q     <= '0;
         tcnt_q        <= '0;
         rom_id_q      <= '0;
         byte_ready_q  <= 1'b0;
         crc_start_q   <= 1'b0;
         crc_bit_q     <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         id_ok_q       <= 1'b0;
         err_crc_q     <= 1'b0;
         err_timeout_q <= 1'b0;
`ifdef ONE_WIRE_FAMILY_CHECK_EN
         family_err_q  <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         byte_cnt_q    <= byte_cnt_d;
         bit_idx_q     <= bit_idx_d;
         tcnt_q        <= tcnt_d;
         rom_id_q      <= rom_id_d;
         byte_ready_q  <= byte_ready_d;
         crc_start_q   <= crc_start_d;
         crc_bit_q     <= crc_bit_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
         id_ok_q       <= id_ok_d;
         err_crc_q     <= err_crc_d;
         err_timeout_q <= err_timeout_d;
`ifdef ONE_WIRE_FAMILY_CHECK_EN
         family_err_q  <= family_err_d;
`endif
      end
   end

   assign byte_ready  = byte_ready_q;
   assign crc_start   = crc_start_q;
   assign crc_bit     = crc_bit_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign id_ok       = id_ok_q;
   assign err_crc     = err_crc_q;
   assign err_timeout = err_timeout_q;
   assign rom_id      = rom_id_q;
`ifdef ONE_WIRE_FAMILY_CHECK_EN
   assign family_err  = family_err_q;
`endif

endmodule

// File: tb/tb_one_wire_rom_id_ctrl.sv
// Directed bench for one_wire_rom_id_ctrl (NUM_BYTES=8, TIMEOUT_CYCLES=16).
module tb_one_wire_rom_id_ctrl;

   localparam logic [63:0] ID_GOOD = 64'hA200000001B81C02;
   localparam logic [63:0] ID_BAD  = 64'hA300000001B81C02;
`ifdef ONE_WIRE_FAMILY_CHECK_EN
   localparam bit FAM_EN = 1'b1;
`else
   localparam bit FAM_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        byte_valid = 1'b0;
   logic [7:0]  byte_data = 8'h00;
   logic        byte_ready;
   logic        crc_start;
   logic        crc_bit;
   logic [7:0]  crc_data = 8'h00;
   logic        crc_valid = 1'b0;
   logic        busy;
   logic        done;
   logic        id_ok;
   logic        err_crc;
   logic        err_timeout;
   logic [63:0] rom_id;
`ifdef ONE_WIRE_FAMILY_CHECK_EN
   logic        family_err;
`endif

   int total = 0;
   int bad   = 0;

   one_wire_rom_id_ctrl #(
      .NUM_BYTES(8),
      .TIMEOUT_CYCLES(16),
      .FAMILY_CODE(8'h28)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .byte_valid(byte_valid),
      .byte_data(byte_data),
      .byte_ready(byte_ready),
      .crc_start(crc_start),
      .crc_bit(crc_bit),
      .crc_data(crc_data),
      .crc_valid(crc_valid),
      .busy(busy),
      .done(done),
      .id_ok(id_ok),
      .err_crc(err_crc),
      .err_timeout(err_timeout),
      .rom_id(rom_id)
`ifdef ONE_WIRE_FAMILY_CHECK_EN
      ,
      .family_err(family_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected id_ok for a CRC-clean result on a given ID.
   function automatic logic exp_ok(input logic [63:0] id);
      return !(FAM_EN && (id[7:0] != 8'h28));
   endfunction

   task automatic send_byte(input logic [7:0] b, input int gap);
      int w;
      byte_valid = 1'b0;
      repeat (gap) tick();
      byte_valid = 1'b1;
      byte_data  = b;
      w = 0;
      while (!byte_ready && w < 20) begin
         tick();
         w++;
      end
      if (w == 20) check("byte_ready_wait", {63'd0, byte_ready}, 64'd1);
      tick();
      byte_valid = 1'b0;
   endtask

   // Start a transaction, push all bytes, then check nbits stream cycles.
   task automatic run_txn(input logic [63:0] id, input bit gaps, input bit spur, input int nbits);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("collect_ready", {63'd0, byte_ready}, 64'd1);
      check("flags_cleared", {61'd0, id_ok, err_crc, err_timeout}, 64'd0);
      for (int k = 0; k < 8; k++) send_byte(id[8*k +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
      for (int i = 0; i < nbits; i++) begin
         check("crc_bit", {63'd0, crc_bit}, {63'd0, id[i]});
         check("crc_start", {63'd0, crc_start}, (i == 0) ? 64'd1 : 64'd0);
         if (i == 0) check("ready_drop", {63'd0, byte_ready}, 64'd0);
         start     = spur && (i == 10);
         crc_valid = spur && (i == 20);
         crc_data  = (spur && (i == 20)) ? 8'h5E : 8'h00;
         tick();
      end
      start     = 1'b0;
      crc_valid = 1'b0;
      crc_data  = 8'h00;
   endtask

   initial begin
      int k;
      // reset state
      tick();
      tick();
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_outs", {58'd0, byte_ready, crc_start, crc_bit, done, id_ok, err_crc}, 64'd0);
      check("rst_err_timeout", {63'd0, err_timeout}, 64'd0);
      check("rst_rom_id", rom_id, 64'd0);
      rst = 1'b0;
      tick();

      // valid ID, result three cycles into the wait
      run_txn(ID_GOOD, 1'b0, 1'b0, 64);
      check("wait_bit_low", {62'd0, crc_start, crc_bit}, 64'd0);
      tick();
      tick();
      crc_valid = 1'b1;
      crc_data  = 8'h00;
      tick();
      crc_valid = 1'b0;
      check("good_done", {63'd0, done}, 64'd1);
      check("good_id_ok", {63'd0, id_ok}, {63'd0, exp_ok(ID_GOOD)});
      check("good_errs", {62'd0, err_crc, err_timeout}, 64'd0);
      check("good_rom_id", rom_id, ID_GOOD);
`ifdef ONE_WIRE_FAMILY_CHECK_EN
      check("good_family_err", {63'd0, family_err}, 64'd1);
`endif
      tick();
      check("good_done_pulse", {62'd0, done, busy}, 64'd0);
      check("good_hold", {63'd0, id_ok}, {63'd0, exp_ok(ID_GOOD)});

      // bad CRC, result on first wait cycle
      run_txn(ID_BAD, 1'b0, 1'b0, 64);
      crc_valid = 1'b1;
      crc_data  = 8'h5E;
      tick();
      crc_valid = 1'b0;
      crc_data  = 8'h00;
      check("bad_done", {63'd0, done}, 64'd1);
      check("bad_err_crc", {63'd0, err_crc}, 64'd1);
      check("bad_id_ok", {63'd0, id_ok}, 64'd0);
      check("bad_err_timeout", {63'd0, err_timeout}, 64'd0);
      check("bad_rom_id", rom_id, ID_BAD);
      tick();

      // timeout: no crc_valid at all
      run_txn(ID_GOOD, 1'b0, 1'b0, 64);
      k = 0;
      while (k < 40) begin
         tick();
         k++;
         if (done) break;
      end
      check("timeout_latency", 64'(k), 64'd16);
      check("timeout_err", {63'd0, err_timeout}, 64'd1);
      check("timeout_id_ok", {62'd0, id_ok, err_crc}, 64'd0);
      tick();

      // crc_valid on the last allowed wait cycle
      run_txn(ID_GOOD, 1'b0, 1'b0, 64);
      repeat (15) tick();
      check("edge_not_done_yet", {63'd0, done}, 64'd0);
      crc_valid = 1'b1;
      crc_data  = 8'h00;
      tick();
      crc_valid = 1'b0;
      check("edge_done", {63'd0, done}, 64'd1);
      check("edge_no_timeout", {63'd0, err_timeout}, 64'd0);
      check("edge_id_ok", {63'd0, id_ok}, {63'd0, exp_ok(ID_GOOD)});
      tick();

      // handshake gaps, spurious start and stray crc_valid during stream
      run_txn(ID_GOOD, 1'b1, 1'b1, 64);
      check("spur_still_waiting", {62'd0, busy, done}, 64'd2);
      crc_valid = 1'b1;
      crc_data  = 8'h00;
      tick();
      crc_valid = 1'b0;
      check("spur_done", {63'd0, done}, 64'd1);
      check("spur_rom_id", rom_id, ID_GOOD);
      check("spur_id_ok", {63'd0, id_ok}, {63'd0, exp_ok(ID_GOOD)});
      check("spur_err_crc", {63'd0, err_crc}, 64'd0);
      tick();
      check("spur_idle", {62'd0, busy, byte_ready}, 64'd0);

      // reset at stream bit 30
      run_txn(ID_BAD, 1'b0, 1'b0, 30);
      check("mid_busy", {63'd0, busy}, 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_outs", {58'd0, byte_ready, crc_start, crc_bit, done, id_ok, err_crc}, 64'd0);
      check("abort_err_timeout", {63'd0, err_timeout}, 64'd0);
      check("abort_rom_id", rom_id, 64'd0);
      repeat (40) begin
         tick();
         if (done) break;
      end
      check("abort_no_done", {62'd0, done, busy}, 64'd0);

      // clean transaction after the abort
      run_txn(ID_GOOD, 1'b0, 1'b0, 64);
      tick();
      crc_valid = 1'b1;
      crc_data  = 8'h00;
      tick();
      crc_valid = 1'b0;
      check("post_done", {63'd0, done}, 64'd1);
      check("post_id_ok", {63'd0, id_ok}, {63'd0, exp_ok(ID_GOOD)});
      check("post_rom_id", rom_id, ID_GOOD);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/one_wire_rom_id_ctrl.md
Name: one_wire_rom_id_ctrl

Overview:
Sequencer that collects a 1-Wire ROM ID byte stream and feeds it bit-serially into the CRC-8 engine. It then judges the engine's result and reports the validated ROM ID. It sits between the 1-Wire byte receiver and the CRC engine instance. The engine interface is a one-cycle start pulse carrying the first bit, then one bit per cycle, with the result flagged by crc_valid.

Parameters:
NUM_BYTES, 8, bytes per ROM ID including the trailing CRC byte (min 2)
TIMEOUT_CYCLES, 16, max cycles to wait for crc_valid after the last bit (min 1)
FAMILY_CODE, 8'h28, expected family byte (used only with the optional feature)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle request to begin a ROM ID check; ignored while busy
byte_valid  in  1  byte_data valid
byte_data  in  8  ROM ID byte, byte 0 (family code) first
byte_ready  out  1  controller accepts a byte; transfer occurs when byte_valid && byte_ready
crc_start  out  1  to engine: start pulse, coincident with bit 0
crc_bit  out  1  to engine: serial data bit
crc_data  in  8  from engine: computed CRC
crc_valid  in  1  from engine: crc_data valid this cycle
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when result flags are updated
id_ok  out  1  ROM ID passed all checks
err_crc  out  1  captured crc_data != 0
err_timeout  out  1  no crc_valid within TIMEOUT_CYCLES
rom_id  out  NUM_BYTES*8  captured ID, byte 0 in bits [7:0]

Behaviour:
- Reset: state IDLE. byte_ready, crc_start, crc_bit, busy, done, id_ok, err_crc, err_timeout = 0. rom_id = 0.
- Reset mid-operation aborts immediately to IDLE with the values above. No partial result is reported.
- IDLE:
  - start=1 -> COLLECT. Clear id_ok, err_crc, err_timeout. Byte counter = 0.
- COLLECT:
  - byte_ready=1.
  - Each accepted byte is written to rom_id[8*k+7:8*k]; k increments.
  - After byte NUM_BYTES-1 is accepted -> STREAM. byte_ready drops the next cycle.
  - No timeout applies in COLLECT. The upstream must finish the transfer or assert rst.
- STREAM: exactly NUM_BYTES*8 consecutive cycles, bit index i = 0..N*8-1.
  - crc_bit = rom_id[i]: byte 0 first, LSB first, matching 1-Wire order.
  - crc_start=1 only when i=0.
  - crc_valid received during STREAM is ignored.
  - After i = N*8-1 -> WAIT_RES with timeout counter = 0.
- WAIT_RES: crc_start=0, crc_bit=0.
  - If crc_valid=1: err_crc = (crc_data != 8'h00) -> DONE.
  - Else the counter increments. When it reaches TIMEOUT_CYCLES-1 without crc_valid: err_timeout=1 -> DONE.
  - crc_valid arriving on the same cycle as the timeout limit is taken as a valid result; no timeout is flagged.
- DONE: one cycle.
  - done=1.
  - id_ok = !err_crc && !err_timeout (&& !family_err when the optional feature is compiled in).
  - -> IDLE.
- Result flags and rom_id hold until the next accepted start or rst.
- start asserted in IDLE on the same cycle as DONE-exit is honoured the following cycle only. start outside IDLE is ignored.
- Latency from last byte accepted to done: N*8 + (cycles until crc_valid) + 1.

Optional Feature:
ONE_WIRE_FAMILY_CHECK_EN
- Defined:
  - Adds output port family_err (1 bit, reset 0).
  - In DONE, family_err = (rom_id[7:0] != FAMILY_CODE), and id_ok also requires !family_err.
  - The CRC stream and the timing are unchanged.
- Undefined: no family_err port; FAMILY_CODE is unused.

Test Plan:
- Valid ID: send bytes 02,1C,B8,01,00,00,00,A2; engine model returns crc_data=00 three cycles after the last bit -> crc_start on bit 0 only, 64 stream bits in order, done pulse, id_ok=1, rom_id=64'hA200000001B81C02.
- Bad CRC: same bytes with last byte A3; model returns crc_data=5E -> done, err_crc=1, id_ok=0.
- Timeout: the model never asserts crc_valid -> done exactly TIMEOUT_CYCLES cycles after entering WAIT_RES, err_timeout=1, id_ok=0. Also check crc_valid on the final allowed cycle -> no timeout.
- Handshake stalls: byte_valid toggled with random gaps; start pulsed during STREAM -> bytes are captured correctly and the spurious start has no effect.
- Reset mid-STREAM at bit 30 -> next cycle busy=0, all flags 0, rom_id=0. A following clean transaction passes.
- With ONE_WIRE_FAMILY_CHECK_EN and FAMILY_CODE=8'h28: the valid ID above (family 02) -> family_err=1, id_ok=0, err_crc=0.
